// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer
// Collects A/B/opcode tokens, drives a combinational ALU, and hands the
// captured result to a consumer over a valid/ready channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int LARGO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LARGO-1:0] alu_a,
    output logic [LARGO-1:0] alu_b,
    output logic [15:0]      alu_op,
    input  logic [LARGO:0]   alu_res,
    output logic [LARGO:0]   res_data,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       op_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t r_state;
    logic   w_xfer;
    logic   w_legal;

    assign in_ready = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);
    assign busy     = (r_state != GET_A);
    assign w_xfer   = in_valid && in_ready;

    // Only add, mult, and, sub, or are implemented by the ALU.
    always_comb begin
        w_legal = 1'b0;
        case (alu_op)
            16'd16, 16'd17, 16'd18, 16'd20, 16'd21: w_legal = 1'b1;
            default:                                 w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= GET_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= 8'd0;
        end else if (clear) begin
            // Abort wins over any transfer or handshake in the same cycle.
            r_state   <= GET_A;
            res_valid <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (w_xfer) begin
                        alu_a   <= in_data[LARGO-1:0];
                        r_state <= GET_B;
                    end
                end
                GET_B: begin
                    if (w_xfer) begin
                        alu_b   <= in_data[LARGO-1:0];
                        r_state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (w_xfer) begin
                        alu_op  <= in_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= w_legal ? alu_res : '0;
                    res_err   <= ~w_legal;
                    res_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        r_state   <= GET_A;
                    end
                end
                default: r_state <= GET_A;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer
// Directed vector bench for alu_cmd_sequencer with a behavioural ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    localparam int LARGO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [LARGO-1:0] alu_a;
    logic [LARGO-1:0] alu_b;
    logic [15:0]      alu_op;
    logic [LARGO:0]   alu_res;
    logic [LARGO:0]   res_data;
    logic             res_err;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       op_count;
    logic             busy;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.LARGO(LARGO)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
        .res_ready(res_ready), .op_count(op_count), .busy(busy)
    );

    // Behavioural stand-in for the external combinational ALU.
    always_comb begin
        logic [2*LARGO-1:0] w_prod;
        w_prod  = alu_a * alu_b;
        alu_res = '0;
        case (alu_op)
            16'd16:  alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            16'd17:  alu_res = w_prod[LARGO:0];
            16'd18:  alu_res = {1'b0, alu_a & alu_b};
            16'd20:  alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            16'd21:  alu_res = {1'b0, alu_a | alu_b};
            default: alu_res = 9'h155;
        endcase
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] op;
        logic [8:0]  ed;
        logic        ee;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_tok(input logic [15:0] d);
        bit done;
        bit rdy;
        done     = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) done = 1'b1;
        end
        if (!done) check("token_timeout", 0, 1);
    endtask

    task automatic wait_res_valid();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (res_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!seen) check("res_valid_timeout", 0, 1);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] op,
                           input logic [8:0] ed, input logic ee);
        send_tok({8'd0, a});
        send_tok({8'd0, b});
        send_tok(op);
        in_valid = 1'b0;
        check("exec_no_valid", res_valid, 0);
        check("exec_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, ed);
        check("res_err", res_err, ee);
        if (res_ready) begin
            @(posedge clk);
            @(negedge clk);
            exp_cnt = exp_cnt + 8'd1;
            check("op_count", op_count, exp_cnt);
            check("valid_dropped", res_valid, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    task automatic quiet_cmd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] op);
        send_tok({8'd0, a});
        send_tok({8'd0, b});
        send_tok(op);
        in_valid = 1'b0;
        wait_res_valid();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{8'd200, 8'd100, 16'd16,     9'h12C, 1'b0};
        tbl[1] = '{8'd3,   8'd5,   16'd20,     9'h1FE, 1'b0};
        tbl[2] = '{8'd20,  8'd30,  16'd17,     9'h058, 1'b0};
        tbl[3] = '{8'hF0,  8'h3C,  16'd18,     9'h030, 1'b0};
        tbl[4] = '{8'hF0,  8'h3C,  16'd21,     9'h0FC, 1'b0};
        tbl[5] = '{8'd7,   8'd9,   16'd19,     9'h000, 1'b1};
        tbl[6] = '{8'hFF,  8'hFF,  16'd16,     9'h1FE, 1'b0};
        tbl[7] = '{8'd0,   8'd1,   16'd20,     9'h1FF, 1'b0};
        tbl[8] = '{8'hFF,  8'hFF,  16'd17,     9'h001, 1'b0};
        tbl[9] = '{8'd2,   8'd3,   16'h0110,   9'h000, 1'b1};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_res_data", res_data, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_cmd(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].ed, tbl[i].ee);

        // Backpressure: result and outputs hold while the consumer stalls.
        res_ready = 1'b0;
        run_cmd(8'd1, 8'd2, 16'd16, 9'h003, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_res_data", res_data, 9'h003);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            check("bp_op_count", op_count, exp_cnt);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        check("bp_release_cnt", op_count, exp_cnt);
        check("bp_release_ready", in_ready, 1);
        check("bp_alu_a_held", alu_a, 1);

        // Clear coinciding with the opcode transfer.
        send_tok(16'd1);
        send_tok(16'd2);
        in_data = 16'd21;
        clear   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_alu_op", alu_op, 16'd16);
        check("clr_alu_b", alu_b, 2);
        @(posedge clk);
        @(negedge clk);
        check("clr_no_valid", res_valid, 0);
        check("clr_op_count", op_count, exp_cnt);
        run_cmd(8'd4, 8'd4, 16'd16, 9'h008, 1'b0);

        // Clear in DONE discards the pending result.
        res_ready = 1'b0;
        run_cmd(8'd5, 8'd5, 16'd16, 9'h00A, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear     = 1'b0;
        res_ready = 1'b1;
        check("clr_done_valid", res_valid, 0);
        check("clr_done_cnt", op_count, exp_cnt);
        check("clr_done_res", res_data, 9'h00A);

        // Asynchronous reset while a result waits in DONE.
        res_ready = 1'b0;
        run_cmd(8'd9, 8'd9, 16'd21, 9'h009, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("areset_valid", res_valid, 0);
        check("areset_data", res_data, 0);
        check("areset_alu_op", alu_op, 0);
        check("areset_cnt", op_count, 0);
        check("areset_ready", in_ready, 1);
        @(negedge clk);
        reset     = 1'b0;
        res_ready = 1'b1;
        exp_cnt   = 8'd0;
        @(negedge clk);

        // op_count wraps after 256 completed commands.
        for (int i = 0; i < 255; i++) quiet_cmd(8'd1, 8'd1, 16'd16);
        check("cnt_255", op_count, 8'd255);
        quiet_cmd(8'd1, 8'd1, 16'd16);
        check("cnt_wrap", op_count, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
